// File: rtl/regfile_wport_arbiter_if.sv
// Write-port bundle between the WB mux / MDU (master side) and the arbiter (slave side).
// The register-file write port, the stall request and the pending mask ride along as arbiter outputs.
interface regfile_wport_arbiter_if;
    logic        i_wb_valid;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_mdu_valid;
    logic        o_mdu_ready;
    logic [4:0]  i_mdu_addr;
    logic [31:0] i_mdu_data;
    logic [4:0]  o_rf_addr;
    logic [31:0] o_rf_data;
    logic        o_stall_req;
    logic [31:0] o_pending_mask;

    modport slave (
        input  i_wb_valid,
        input  i_wb_addr,
        input  i_wb_data,
        input  i_mdu_valid,
        input  i_mdu_addr,
        input  i_mdu_data,
        output o_mdu_ready,
        output o_rf_addr,
        output o_rf_data,
        output o_stall_req,
        output o_pending_mask
    );

    modport master (
        output i_wb_valid,
        output i_wb_addr,
        output i_wb_data,
        output i_mdu_valid,
        output i_mdu_addr,
        output i_mdu_data,
        input  o_mdu_ready,
        input  o_rf_addr,
        input  o_rf_data,
        input  o_stall_req,
        input  o_pending_mask
    );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port: WB has fixed priority, MDU results queue in a small
// in-order FIFO and drain on idle WB cycles; a starvation FSM requests a WB bubble.
module regfile_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                    i_clk,
    input logic                    i_reset,
    regfile_wport_arbiter_if.slave wp
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STALL
    } state_e;

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d, starve_inc;
    state_e           state_q, state_d;
    logic             stall_q, stall_d;

    logic wb_req;
    logic empty;
    logic full;
    logic pop;
    logic accept;
    logic push;

    assign wb_req = wp.i_wb_valid && (wp.i_wb_addr != 5'd0);
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign pop    = !wb_req && !empty;
    // Address-0 results complete the handshake but are never stored.
    assign accept = wp.i_mdu_valid && !full;
    assign push   = accept && (wp.i_mdu_addr != 5'd0);

    assign wp.o_mdu_ready = !full;
    assign wp.o_stall_req = stall_q;

    always_comb begin
        wp.o_rf_addr = 5'd0;
        wp.o_rf_data = 32'd0;
        if (!i_reset) begin
            if (wb_req) begin
                wp.o_rf_addr = wp.i_wb_addr;
                wp.o_rf_data = wp.i_wb_data;
            end else if (!empty) begin
                wp.o_rf_addr = addr_q[rd_ptr_q];
                wp.o_rf_data = data_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        wp.o_pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) wp.o_pending_mask[addr_q[i]] = 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        vld_d    = vld_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d        = rd_ptr_q + 1'b1;
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d        = wr_ptr_q + 1'b1;
            vld_d[wr_ptr_q] = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            vld_q    <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            vld_q    <= vld_d;
            count_q  <= count_d;
            if (push) begin
                addr_q[wr_ptr_q] <= wp.i_mdu_addr;
                data_q[wr_ptr_q] <= wp.i_mdu_data;
            end
        end
    end

    // Saturating increment; the limit compare uses the post-increment value so
    // the stall flop rises on the edge where the counter reaches the limit.
    assign starve_inc = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        stall_d  = stall_q;
        case (state_q)
            S_IDLE: begin
                starve_d = '0;
                stall_d  = 1'b0;
                if (count_d != '0) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pop) begin
                    starve_d = '0;
                    if (count_d == '0) state_d = S_IDLE;
                end else if (!empty) begin
                    starve_d = starve_inc;
                    if (starve_inc == SW'(STARVE_LIMIT)) begin
                        state_d = S_STALL;
                        stall_d = 1'b1;
                    end
                end
            end
            S_STALL: begin
                stall_d = 1'b1;
                if (pop) begin
                    stall_d  = 1'b0;
                    starve_d = '0;
                    state_d  = (count_d == '0) ? S_IDLE : S_WAIT;
                end
            end
            default: begin
                state_d  = S_IDLE;
                starve_d = '0;
                stall_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter (DEPTH=2, STARVE_LIMIT=4) with hand-computed expectations.
module tb_regfile_wport_arbiter;
    logic i_clk = 1'b0;
    logic i_reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    regfile_wport_arbiter_if bus ();

    regfile_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .wp      (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Start of a cycle: inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drv(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.i_wb_valid  = wv;
        bus.i_wb_addr   = wa;
        bus.i_wb_data   = wd;
        bus.i_mdu_valid = mv;
        bus.i_mdu_addr  = ma;
        bus.i_mdu_data  = md;
    endtask

    initial begin
        i_reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_ready", 32'(bus.o_mdu_ready), 32'd1);
        chk("rst_rfaddr", 32'(bus.o_rf_addr), 32'd0);
        chk("rst_mask", bus.o_pending_mask, 32'd0);
        chk("rst_stall", 32'(bus.o_stall_req), 32'd0);
        #9 i_reset = 1'b0;

        // WB only
        cyc(); drv(1, 5, 32'hDEADBEEF, 0, 0, 0); #4;
        chk("wb_addr", 32'(bus.o_rf_addr), 32'd5);
        chk("wb_data", bus.o_rf_data, 32'hDEADBEEF);
        cyc(); drv(1, 0, 32'hCAFEF00D, 0, 0, 0); #4;
        chk("wb_r0_addr", 32'(bus.o_rf_addr), 32'd0);
        chk("wb_r0_data", bus.o_rf_data, 32'd0);

        // MDU into idle port: no bypass, drains next cycle
        cyc(); drv(0, 0, 0, 1, 9, 32'h12345678); #4;
        chk("mdu_nobypass", 32'(bus.o_rf_addr), 32'd0);
        chk("mdu_ready", 32'(bus.o_mdu_ready), 32'd1);
        cyc(); drv(0, 0, 0, 0, 0, 0); #4;
        chk("mdu_addr", 32'(bus.o_rf_addr), 32'd9);
        chk("mdu_data", bus.o_rf_data, 32'h12345678);
        chk("mdu_mask", bus.o_pending_mask, 32'h200);
        cyc(); #4;
        chk("mdu_mask_clr", bus.o_pending_mask, 32'd0);
        chk("mdu_idle", 32'(bus.o_rf_addr), 32'd0);

        // Priority and full
        cyc(); drv(1, 1, 32'h11, 1, 3, 32'h33); #4;
        chk("pri_wb", 32'(bus.o_rf_addr), 32'd1);
        cyc(); drv(1, 1, 32'h11, 1, 4, 32'h44); #4;
        chk("pri_ready1", 32'(bus.o_mdu_ready), 32'd1);
        chk("pri_mask1", bus.o_pending_mask, 32'h8);
        cyc(); drv(1, 1, 32'h11, 0, 0, 0); #4;
        chk("full_ready", 32'(bus.o_mdu_ready), 32'd0);
        chk("full_mask", bus.o_pending_mask, 32'h18);
        cyc(); drv(0, 0, 0, 0, 0, 0); #4;
        chk("drain1_addr", 32'(bus.o_rf_addr), 32'd3);
        chk("drain1_data", bus.o_rf_data, 32'h33);
        chk("drain1_ready", 32'(bus.o_mdu_ready), 32'd0);
        cyc(); #4;
        chk("drain2_addr", 32'(bus.o_rf_addr), 32'd4);
        chk("drain2_data", bus.o_rf_data, 32'h44);
        chk("drain2_ready", 32'(bus.o_mdu_ready), 32'd1);
        chk("drain2_mask", bus.o_pending_mask, 32'h10);
        cyc(); #4;
        chk("drain_done", bus.o_pending_mask, 32'd0);
        chk("drain_stall", 32'(bus.o_stall_req), 32'd0);

        // Starvation: four pop-less cycles then stall
        cyc(); drv(1, 2, 32'h22, 1, 7, 32'h77); #4;
        for (int i = 0; i < 4; i++) begin
            cyc(); drv(1, 2, 32'h22, 0, 0, 0); #4;
            chk("starve_pre", 32'(bus.o_stall_req), 32'd0);
        end
        cyc(); drv(0, 0, 0, 0, 0, 0); #4;
        chk("starve_stall", 32'(bus.o_stall_req), 32'd1);
        chk("starve_drain", 32'(bus.o_rf_addr), 32'd7);
        cyc(); #4;
        chk("starve_clr", 32'(bus.o_stall_req), 32'd0);
        chk("starve_mask", bus.o_pending_mask, 32'd0);

        // Push while popping: count stays 1, order kept
        cyc(); drv(0, 0, 0, 1, 10, 32'hA); #4;
        cyc(); drv(0, 0, 0, 1, 11, 32'hB); #4;
        chk("pp_pop", 32'(bus.o_rf_addr), 32'd10);
        chk("pp_ready", 32'(bus.o_mdu_ready), 32'd1);
        cyc(); drv(0, 0, 0, 0, 0, 0); #4;
        chk("pp_next", 32'(bus.o_rf_addr), 32'd11);
        chk("pp_data", bus.o_rf_data, 32'hB);
        chk("pp_mask", bus.o_pending_mask, 32'h800);
        cyc(); #4;
        chk("pp_empty", 32'(bus.o_rf_addr), 32'd0);

        // MDU addr 0 accepted but not stored
        cyc(); drv(1, 2, 32'h22, 1, 12, 32'hC); #4;
        cyc(); drv(1, 2, 32'h22, 1, 0, 32'hDEAD); #4;
        chk("a0_ready", 32'(bus.o_mdu_ready), 32'd1);
        cyc(); drv(1, 2, 32'h22, 0, 0, 0); #4;
        chk("a0_mask", bus.o_pending_mask, 32'h1000);
        chk("a0_notfull", 32'(bus.o_mdu_ready), 32'd1);
        cyc(); drv(0, 0, 0, 0, 0, 0); #4;
        chk("a0_drain", 32'(bus.o_rf_addr), 32'd12);
        cyc(); #4;
        chk("a0_nowrite", 32'(bus.o_rf_addr), 32'd0);
        chk("a0_mask_clr", bus.o_pending_mask, 32'd0);

        // Pop on the limit cycle: no stall
        cyc(); drv(1, 2, 32'h22, 1, 13, 32'hD); #4;
        for (int i = 0; i < 3; i++) begin
            cyc(); drv(1, 2, 32'h22, 0, 0, 0); #4;
        end
        cyc(); drv(0, 0, 0, 0, 0, 0); #4;
        chk("lim_pop", 32'(bus.o_rf_addr), 32'd13);
        chk("lim_nostall0", 32'(bus.o_stall_req), 32'd0);
        cyc(); #4;
        chk("lim_nostall1", 32'(bus.o_stall_req), 32'd0);

        // Reset mid-operation with a full FIFO
        cyc(); drv(1, 2, 32'h22, 1, 14, 32'hE); #4;
        cyc(); drv(1, 2, 32'h22, 1, 15, 32'hF); #4;
        cyc(); drv(1, 2, 32'h22, 0, 0, 0); #2;
        chk("mr_mask_pre", bus.o_pending_mask, 32'hC000);
        #1 i_reset = 1'b1;
        #1;
        chk("mr_mask", bus.o_pending_mask, 32'd0);
        chk("mr_ready", 32'(bus.o_mdu_ready), 32'd1);
        chk("mr_rfaddr", 32'(bus.o_rf_addr), 32'd0);
        cyc(); drv(0, 0, 0, 0, 0, 0); #3;
        i_reset = 1'b0;
        cyc(); #4;
        chk("mr_stall", 32'(bus.o_stall_req), 32'd0);
        chk("mr_discard", 32'(bus.o_rf_addr), 32'd0);
        chk("mr_mask_post", bus.o_pending_mask, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
